// File: rtl/isq_issue_pipe.sv
// isq_issue_pipe
// Issue-to-execute buffer stage sitting directly behind the issue queue's
// dequeue port. Holds up to DEPTH micro-ops in arrival order, presents the
// oldest to execute with a valid/ready handshake, and drops any entry
// (including the one arriving this cycle) that is younger than a flushing
// ROB id.
//
// Ports:
//   clock          system clock
//   reset_n        asynchronous active-low reset
//   in_valid       issue queue presents a micro-op
//   in_ready       stage can accept (depends on registered state only)
//   in_data        micro-op payload; robid lives in the top ROB_SIZE_LOG+1 bits
//   out_valid      head micro-op available to execute
//   out_ready      execute unit accepts the head
//   out_data       head payload (0 when the head slot is empty)
//   flush_valid    rollback in progress this cycle
//   flush_robid    robid of the flushing instruction
//   occupancy      number of valid slots
//   flush_kill_cnt saturating count of entries killed by flush
module isq_issue_pipe #(
    parameter int DATA_WIDTH   = 248,
    parameter int ROB_SIZE_LOG = 6,
    parameter int DEPTH        = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_WIDTH-1:0]        out_data,
    input  logic                         flush_valid,
    input  logic [ROB_SIZE_LOG:0]        flush_robid,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy,
    output logic [7:0]                   flush_kill_cnt
);

    localparam int RW = ROB_SIZE_LOG + 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int KW = CW + 1;

    logic [DEPTH-1:0]      slot_valid;
    logic [DATA_WIDTH-1:0] slot_data [DEPTH];
    logic [7:0]            kill_cnt;

    logic [DEPTH-1:0]      slot_kill;
    logic [DEPTH-1:0]      keep;
    logic [CW-1:0]         pos [DEPTH];
    logic [CW-1:0]         occ;
    logic [CW-1:0]         surv_cnt;
    logic [KW-1:0]         kill_sum;
    logic                  in_kill;
    logic                  pop;
    logic                  push;
    logic [DEPTH-1:0]      next_valid;
    logic [DATA_WIDTH-1:0] next_data [DEPTH];
    logic [8:0]            kill_cnt_sum;

    // Age compare across the ROB wrap bit: when the wrap bits differ the
    // index comparison is inverted. Equal robids are not younger.
    function automatic logic younger(input logic [RW-1:0] r, input logic [RW-1:0] f);
        return (r[RW-1] ^ f[RW-1]) ^ (f[RW-2:0] < r[RW-2:0]);
    endfunction

    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_kill[i] = flush_valid & slot_valid[i]
                         & younger(slot_data[i][DATA_WIDTH-1 -: RW], flush_robid);
            occ = occ + CW'(slot_valid[i]);
        end
    end

    assign in_ready  = (occ < CW'(DEPTH));
    assign occupancy = occ;
    assign out_valid = slot_valid[0] & ~slot_kill[0];
    assign out_data  = slot_valid[0] ? slot_data[0] : '0;
    assign pop       = out_valid & out_ready;
    assign in_kill   = in_valid & in_ready & flush_valid
                     & younger(in_data[DATA_WIDTH-1 -: RW], flush_robid);
    assign push      = in_valid & in_ready & ~in_kill;

    // Survivors keep their relative order; pos[i] is the slot a surviving
    // entry i lands in after the killed/popped ones are squeezed out.
    always_comb begin
        surv_cnt = '0;
        kill_sum = KW'(in_kill);
        for (int i = 0; i < DEPTH; i++) begin
            keep[i]  = slot_valid[i] & ~slot_kill[i] & ~((i == 0) ? pop : 1'b0);
            pos[i]   = surv_cnt;
            surv_cnt = surv_cnt + CW'(keep[i]);
            kill_sum = kill_sum + KW'(slot_kill[i]);
        end
    end

    // Each destination slot picks the survivor compacted into it, or the
    // incoming op when it sits right after the last survivor. Payloads of
    // slots left empty simply hold their old contents.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            next_valid[j] = 1'b0;
            next_data[j]  = slot_data[j];
            for (int i = 0; i < DEPTH; i++) begin
                if (keep[i] && (pos[i] == CW'(j))) begin
                    next_valid[j] = 1'b1;
                    next_data[j]  = slot_data[i];
                end
            end
            if (push && (surv_cnt == CW'(j))) begin
                next_valid[j] = 1'b1;
                next_data[j]  = in_data;
            end
        end
    end

    assign kill_cnt_sum   = {1'b0, kill_cnt} + 9'(kill_sum);
    assign flush_kill_cnt = kill_cnt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            slot_valid <= '0;
            kill_cnt   <= '0;
        end else begin
            slot_valid <= next_valid;
            kill_cnt   <= kill_cnt_sum[8] ? 8'hFF : kill_cnt_sum[7:0];
        end
    end

    // Payload storage is deliberately not reset; validity alone qualifies it.
    always_ff @(posedge clock) begin
        for (int j = 0; j < DEPTH; j++) begin
            slot_data[j] <= next_data[j];
        end
    end

endmodule
